// File: rtl/picorv32_mem_pkg.sv
// Shared types and defaults for the picorv32 SRAM responder.
// Holds the responder FSM state encoding, the error read-data default
// and the latency-counter type (wide enough for RD_LATENCY-1 up to 3).
package picorv32_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } resp_state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // RD_LATENCY is limited to 1..4, so the counter only ever holds 0..3.
  localparam int LAT_CNT_W = 2;
  typedef logic [LAT_CNT_W-1:0] lat_cnt_t;

endpackage

// File: rtl/picorv32_sram_responder.sv
// Memory-side responder between the picorv32 native bus and a 1-port SRAM.
// Latency: writes/out-of-range complete 1 cycle after issue, reads RD_LATENCY+1.
// Backpressure: one access in flight; mem_valid is ignored until back in IDLE.
module picorv32_sram_responder
  import picorv32_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          ADDR_W     = 9,
  parameter int          RD_LATENCY = 1,
  parameter logic [31:0] ERR_DATA   = ERR_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  input  logic              mem_instr,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic              sram_csb,
  output logic              sram_web,
  output logic [3:0]        sram_wmask,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_din,
  input  logic [31:0]       sram_dout,
  output logic              bus_err,
  output logic [31:0]       err_addr,
  output logic              err_instr
);

  // Everything above the word-address bits and the byte offset selects the window.
  localparam logic [31:0] WIN_MASK = ~((32'd4 << ADDR_W) - 32'd1);
  localparam lat_cnt_t    LAT_INIT = lat_cnt_t'(RD_LATENCY - 1);

  resp_state_t state, state_next;
  lat_cnt_t    lat_cnt, lat_cnt_next;
  logic        ready_next;
  logic        err_next;
  logic        err_load;
  logic        rdata_load;
  logic [31:0] rdata_next;
  logic        in_range;
  logic        issue;

  assign in_range = (mem_addr & WIN_MASK) == BASE_ADDR;
  // Reset gating keeps the macro deselected no matter what the core drives.
  assign issue    = resetn && (state == IDLE) && mem_valid;

  // Address and data always pass through; only the strobes are qualified.
  assign sram_addr = mem_addr[ADDR_W+1:2];
  assign sram_din  = mem_wdata;

  // SRAM strobes: asserted only in the issue cycle of an in-range access.
  always_comb begin
    sram_csb   = 1'b1;
    sram_web   = 1'b1;
    sram_wmask = 4'h0;
    if (issue && in_range) begin
      sram_csb   = 1'b0;
      sram_web   = (mem_wstrb == 4'h0);
      sram_wmask = mem_wstrb;
    end
  end

  // Next-state logic plus the registered completion/error outputs it feeds.
  always_comb begin
    state_next   = state;
    lat_cnt_next = lat_cnt;
    ready_next   = 1'b0;
    err_next     = 1'b0;
    err_load     = 1'b0;
    rdata_load   = 1'b0;
    rdata_next   = mem_rdata;
    unique case (state)
      IDLE: begin
        if (mem_valid) begin
          if (!in_range) begin
            // No SRAM access; complete next cycle with an error flag.
            state_next = RESP;
            ready_next = 1'b1;
            err_next   = 1'b1;
            err_load   = 1'b1;
            if (mem_wstrb == 4'h0) begin
              rdata_load = 1'b1;
              rdata_next = ERR_DATA;
            end
          end else if (mem_wstrb != 4'h0) begin
            state_next = RESP;
            ready_next = 1'b1;
          end else begin
            state_next   = RD_WAIT;
            lat_cnt_next = LAT_INIT;
          end
        end
      end
      RD_WAIT: begin
        if (lat_cnt == lat_cnt_t'(0)) begin
          // sram_dout is valid in this cycle; register it for the RESP cycle.
          state_next = RESP;
          ready_next = 1'b1;
          rdata_load = 1'b1;
          rdata_next = sram_dout;
        end else begin
          lat_cnt_next = lat_cnt - lat_cnt_t'(1);
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      lat_cnt   <= lat_cnt_t'(0);
      mem_ready <= 1'b0;
      mem_rdata <= 32'h0;
      bus_err   <= 1'b0;
      err_addr  <= 32'h0;
      err_instr <= 1'b0;
    end else begin
      state     <= state_next;
      lat_cnt   <= lat_cnt_next;
      mem_ready <= ready_next;
      bus_err   <= err_next;
      if (rdata_load) begin
        mem_rdata <= rdata_next;
      end
      if (err_load) begin
        err_addr  <= mem_addr;
        err_instr <= mem_instr;
      end
    end
  end

endmodule
